pcpi_dispatch: RTL
==================

PCPI_DISPATCH -- requirements
Module: pcpi_dispatch

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width (32 or 64).
REQ-002 SHALL have parameter ILL_TIMEOUT, default 16, cycles before an unclaimed instruction is reported illegal (2..255).
REQ-003 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pcpi_valid  input  1  core request, held until pcpi_ready or core abort.
REQ-006 SHALL have port pcpi_insn  input  32  instruction word.
REQ-007 SHALL have ports pcpi_rs1_data and pcpi_rs2_data  input  XLEN  operands.
REQ-008 SHALL have port pcpi_ready  output  1  one-cycle completion pulse to core.
REQ-009 SHALL have port pcpi_wb_write  output  1  rd writeback enable, valid with pcpi_ready.
REQ-010 SHALL have port pcpi_wb_data  output  XLEN  writeback value, valid with pcpi_ready.
REQ-011 SHALL have port pcpi_illegal  output  1  illegal-instruction flag, valid with pcpi_ready.
REQ-012 SHALL have ports mul_valid and div_valid  output  1  per-unit request strobes.
REQ-013 SHALL have ports unit_insn  output  32, unit_rs1 and unit_rs2  output  XLEN  registered request to both units.
REQ-014 SHALL have ports mul_ready, mul_wr, div_ready, div_wr  input  1, mul_rd and div_rd  input  XLEN  unit responses.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, ILL, RESP, DRAIN.
REQ-016 In IDLE with pcpi_valid=1: SHALL latch insn/rs1/rs2 into unit_* registers and decode next cycle-edge.
REQ-017 Decode: opcode 0110011 and funct7 0000001 -> funct3 0-3 to MUL, 4-7 to DIV.
REQ-018 Decode (XLEN=64 only): opcode 0111011 and funct7 0000001 -> funct3 0 to MUL, 4-7 to DIV, W flag set; funct3 1-3 -> ILL.
REQ-019 Every other encoding SHALL go to ILL.
REQ-020 mul_valid SHALL be 1 throughout MUL; div_valid 1 throughout DIV; never both.
REQ-021 In MUL, mul_ready=1: SHALL capture mul_wr/mul_rd and enter RESP. DIV with div_ready is handled identically.
REQ-022 Responses from the non-selected unit, or arriving in any other state, SHALL be ignored.
REQ-023 W flag set: wb_data SHALL be the result[31:0] sign-extended to XLEN.
REQ-024 ILL SHALL count ILL_TIMEOUT cycles, then enter RESP with illegal=1 and wb_write=0.
REQ-025 RESP SHALL assert pcpi_ready for exactly one cycle, then enter DRAIN.
REQ-026 Latency: pcpi_ready SHALL occur exactly 1 cycle after the accepted unit ready.
REQ-027 DRAIN SHALL return to IDLE only when pcpi_valid=0, so no request is issued twice.
REQ-028 pcpi_valid falling in MUL, DIV or ILL (abort): SHALL drop the unit strobe, enter IDLE, and emit no pcpi_ready.
REQ-029 pcpi_wb_write, pcpi_wb_data and pcpi_illegal SHALL be 0 whenever pcpi_ready=0.

Reset
REQ-030 reset SHALL force IDLE and set pcpi_ready, pcpi_wb_write, pcpi_illegal, mul_valid, div_valid, pcpi_wb_data and the timeout counter to 0.
REQ-031 Reset mid-operation SHALL discard the in-flight request, and later unit responses SHALL be ignored.
REQ-032 unit_insn, unit_rs1 and unit_rs2 need not be reset.

Structure
REQ-033 Shared package pcpi_pkg SHALL hold the opcode constants (OP 0110011, OP_32 0111011), funct7 MULDIV 0000001 and the FSM state enum.
REQ-034 Decode SHALL be a combinational sub-module pcpi_m_decode (insn -> is_mul, is_div, is_w, illegal).

Verification
REQ-035 MUL 7*6: issue; mul_ready with rd=42 -> pcpi_ready 1 cycle later, wb_write=1, wb_data=42, illegal=0.
REQ-036 DIVW (XLEN=64), div_rd=0x00000000_FFFFFFF9 -> wb_data=0xFFFFFFFF_FFFFFFF9.
REQ-037 insn 0x00000013 (ADDI) -> pcpi_ready exactly ILL_TIMEOUT+2 cycles after pcpi_valid, illegal=1, wb_write=0.
REQ-038 MULHU with opcode OP_32 -> illegal path; mul_valid never asserted.
REQ-039 Abort: drop pcpi_valid 3 cycles into DIV, then div_ready -> no pcpi_ready; next MUL completes correctly.
REQ-040 Hold pcpi_valid 5 cycles after pcpi_ready -> single pcpi_ready; stray mul_ready during DIV ignored.

Source files
------------

// File: rtl/pcpi_pkg.sv
// Shared encodings, FSM state set and decode payload for the PCPI mul/div dispatcher.
package pcpi_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_32  = 7'b0111011;
    localparam logic [6:0] MULDIV = 7'b0000001;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL   = 3'd1,
        ST_DIV   = 3'd2,
        ST_ILL   = 3'd3,
        ST_RESP  = 3'd4,
        ST_DRAIN = 3'd5
    } pcpi_state_e;

    typedef struct packed {
        logic is_mul;
        logic is_div;
        logic is_w;
        logic illegal;
    } pcpi_dec_t;

    function automatic logic [6:0] insn_opcode(input logic [31:0] insn);
        return insn[6:0];
    endfunction

    function automatic logic [6:0] insn_funct7(input logic [31:0] insn);
        return insn[31:25];
    endfunction

endpackage

// File: rtl/pcpi_m_decode.sv
// Combinational M-extension classifier: routes an instruction to MUL, DIV or the illegal path.
module pcpi_m_decode
    import pcpi_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0] insn,
    output logic        is_mul,
    output logic        is_div,
    output logic        is_w,
    output logic        illegal
);

    localparam bit RV64 = (XLEN == 64);

    pcpi_dec_t dec;
    logic      muldiv_f7;
    logic      unused_fields;

    assign muldiv_f7     = (insn_funct7(insn) == MULDIV);
    assign unused_fields = ^{insn[24:15], insn[11:7]};

    // funct3[2] splits MUL (0-3) from DIV (4-7); OP_32 only has MULW at funct3=0
    always_comb begin
        dec = '{is_mul: 1'b0, is_div: 1'b0, is_w: 1'b0, illegal: 1'b1};
        if (insn_opcode(insn) == OP && muldiv_f7) begin
            dec.is_mul  = ~insn[14];
            dec.is_div  = insn[14];
            dec.illegal = 1'b0;
        end else if (RV64 && insn_opcode(insn) == OP_32 && muldiv_f7) begin
            if (insn[14]) begin
                dec.is_div  = 1'b1;
                dec.is_w    = 1'b1;
                dec.illegal = 1'b0;
            end else if (insn[13:12] == 2'b00) begin
                dec.is_mul  = 1'b1;
                dec.is_w    = 1'b1;
                dec.illegal = 1'b0;
            end
        end
    end

    assign is_mul  = dec.is_mul;
    assign is_div  = dec.is_div;
    assign is_w    = dec.is_w;
    assign illegal = dec.illegal;

endmodule

// File: rtl/pcpi_dispatch.sv
// PCPI front end: latches a core request, dispatches it to the multiplier or divider,
// times out unclaimed encodings as illegal and returns a single completion pulse.
module pcpi_dispatch
    import pcpi_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned ILL_TIMEOUT = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            pcpi_valid,
    input  logic [31:0]     pcpi_insn,
    input  logic [XLEN-1:0] pcpi_rs1_data,
    input  logic [XLEN-1:0] pcpi_rs2_data,
    output logic            pcpi_ready,
    output logic            pcpi_wb_write,
    output logic [XLEN-1:0] pcpi_wb_data,
    output logic            pcpi_illegal,
    output logic            mul_valid,
    output logic            div_valid,
    output logic [31:0]     unit_insn,
    output logic [XLEN-1:0] unit_rs1,
    output logic [XLEN-1:0] unit_rs2,
    input  logic            mul_ready,
    input  logic            mul_wr,
    input  logic [XLEN-1:0] mul_rd,
    input  logic            div_ready,
    input  logic            div_wr,
    input  logic [XLEN-1:0] div_rd
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ILL_TIMEOUT - 1);

    pcpi_state_e      state, state_n;
    logic             dec_pend, dec_pend_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             is_w_q, is_w_n;
    logic             latch;

    logic             ready_n;
    logic             wb_write_n;
    logic [XLEN-1:0]  wb_data_n;
    logic             illegal_n;

    logic             hit;
    logic             wr_sel;
    logic [XLEN-1:0]  rd_sel;
    logic [XLEN-1:0]  rd_w;

    logic             dec_is_mul;
    logic             dec_is_div;
    logic             dec_is_w;
    logic             dec_illegal;

    pcpi_m_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .insn    (unit_insn),
        .is_mul  (dec_is_mul),
        .is_div  (dec_is_div),
        .is_w    (dec_is_w),
        .illegal (dec_illegal)
    );

    assign rd_w = XLEN'($signed(rd_sel[31:0]));

    // Next-state and next-output logic; a request is latched in IDLE and decoded one edge later
    always_comb begin
        state_n    = state;
        dec_pend_n = dec_pend;
        cnt_n      = cnt;
        is_w_n     = is_w_q;
        latch      = 1'b0;
        ready_n    = 1'b0;
        wb_write_n = 1'b0;
        wb_data_n  = '0;
        illegal_n  = 1'b0;
        hit        = 1'b0;
        wr_sel     = 1'b0;
        rd_sel     = '0;

        case (state)
            ST_IDLE: begin
                if (dec_pend) begin
                    dec_pend_n = 1'b0;
                    if (pcpi_valid) begin
                        is_w_n = dec_is_w;
                        cnt_n  = '0;
                        if (dec_illegal) begin
                            state_n = ST_ILL;
                        end else if (dec_is_mul) begin
                            state_n = ST_MUL;
                        end else begin
                            state_n = ST_DIV;
                        end
                    end
                end else if (pcpi_valid) begin
                    latch      = 1'b1;
                    dec_pend_n = 1'b1;
                end
            end
            ST_MUL: begin
                if (!pcpi_valid) begin
                    state_n = ST_IDLE;
                end else if (mul_ready) begin
                    hit    = 1'b1;
                    wr_sel = mul_wr;
                    rd_sel = mul_rd;
                end
            end
            ST_DIV: begin
                if (!pcpi_valid) begin
                    state_n = ST_IDLE;
                end else if (div_ready) begin
                    hit    = 1'b1;
                    wr_sel = div_wr;
                    rd_sel = div_rd;
                end
            end
            ST_ILL: begin
                if (!pcpi_valid) begin
                    state_n = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_n   = ST_RESP;
                    ready_n   = 1'b1;
                    illegal_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_n = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!pcpi_valid) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (hit) begin
            state_n    = ST_RESP;
            ready_n    = 1'b1;
            wb_write_n = wr_sel;
            wb_data_n  = is_w_q ? rd_w : rd_sel;
        end
    end

    // State and registered outputs; unit strobes follow the state being entered
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            dec_pend      <= 1'b0;
            cnt           <= '0;
            is_w_q        <= 1'b0;
            pcpi_ready    <= 1'b0;
            pcpi_wb_write <= 1'b0;
            pcpi_wb_data  <= '0;
            pcpi_illegal  <= 1'b0;
            mul_valid     <= 1'b0;
            div_valid     <= 1'b0;
        end else begin
            state         <= state_n;
            dec_pend      <= dec_pend_n;
            cnt           <= cnt_n;
            is_w_q        <= is_w_n;
            pcpi_ready    <= ready_n;
            pcpi_wb_write <= wb_write_n;
            pcpi_wb_data  <= wb_data_n;
            pcpi_illegal  <= illegal_n;
            mul_valid     <= (state_n == ST_MUL);
            div_valid     <= (state_n == ST_DIV);
        end
    end

    // Request payload shared by both units
    always_ff @(posedge clock) begin
        if (latch) begin
            unit_insn <= pcpi_insn;
            unit_rs1  <= pcpi_rs1_data;
            unit_rs2  <= pcpi_rs2_data;
        end
    end

endmodule
